mips_memory_data_port: RTL and testbench
========================================

MIPS_MEMORY_DATA_PORT -- requirements
Module: mips_memory_data_port

Interface
REQ-001 SHALL: clock  input  1  sole clock, all state on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high; one clock and synchronous active-high reset are fixed.
REQ-003 SHALL: in_valid / in_ready  input / output  1 / 1  request handshake from the pipeline memory stage.
REQ-004 SHALL: write_enable  input  1  1 = store, 0 = load.
REQ-005 SHALL: byte_enable  input  2  access size: 0 None, 1 Byte, 2 Half, 3 Word.
REQ-006 SHALL: byte_extend  input  1  load extension: 0 Signed, 1 Unsigned.
REQ-007 SHALL: address / store_data  input  32 / 32  byte address and store operand.
REQ-008 SHALL: out_valid / load_data / fault  output  1 / 32 / 1  completion pulse, extended load result, misalignment flag.
REQ-009 SHALL: mem_req / mem_we / mem_addr / mem_wstrb / mem_wdata  output  1 / 1 / 30 / 4 / 32  word-RAM request, with mem_addr as the word address.
REQ-010 SHALL: mem_gnt / mem_rvalid / mem_rdata  input  1 / 1 / 32  grant, read-data valid, read data.

Function
REQ-011 SHALL: FSM states are IDLE, REQ, WAIT, DONE; in_ready = 1 only in IDLE; a request is accepted on in_valid & in_ready, which latches all inputs.
REQ-012 SHALL: an accepted byte_enable = None request goes IDLE->DONE with no mem_req, load_data = 0, fault = 0.
REQ-013 SHALL: an accepted aligned request goes IDLE->REQ; mem_req, mem_we, mem_addr = address[31:2], mem_wstrb and mem_wdata hold stable in REQ until mem_gnt.
REQ-014 SHALL: strobes (little-endian lanes, a = address[1:0]) are Byte 4'b0001<<a, Half 4'b0011<<a, Word 4'b1111.
REQ-015 SHALL: mem_wdata is store_data[7:0] replicated x4 for Byte, store_data[15:0] x2 for Half, store_data for Word.
REQ-016 SHALL: on a store, mem_gnt moves the FSM to DONE; on a load, mem_gnt moves it to WAIT; mem_req and mem_wstrb are 0 outside REQ.
REQ-017 SHALL: in WAIT, mem_rvalid captures (mem_rdata >> 8*a), masked to 8/16/32 bits, sign- or zero-extended per byte_extend, into load_data, then moves to DONE; mem_rvalid outside WAIT is ignored.
REQ-018 SHALL: DONE asserts out_valid for exactly one cycle and then returns to IDLE; load_data holds until the next completion; stores leave load_data unchanged.
REQ-019 SHALL: minimum load latency (zero-wait RAM, gnt in the first REQ cycle, rvalid the next cycle) is accept N -> out_valid N+3; minimum store latency is N+2.
REQ-020 SHALL: misalignment is Half with a[0] = 1 or Word with a != 0; its handling is governed by REQ-024/025.

Reset
REQ-021 SHALL: reset forces IDLE; in_ready = 1; out_valid, fault, mem_req, mem_we = 0; mem_wstrb = 0; mem_addr, mem_wdata, load_data = 0.
REQ-022 SHALL: reset asserted mid-operation (REQ/WAIT/DONE) abandons the access, drops mem_req the next cycle, and ignores any later mem_rvalid belonging to it.
REQ-023 SHALL: reset has priority over every handshake event in the same cycle.

Configuration
REQ-024 SHALL: without MIPS_MEMORY_DATA_PORT_UNALIGNED_EN, a misaligned request goes IDLE->DONE with fault = 1 and out_valid for one cycle, issues no mem_req, and leaves load_data unchanged.
REQ-025 SHALL: with MIPS_MEMORY_DATA_PORT_UNALIGNED_EN defined, a misaligned access that crosses a word boundary is split by added states REQ2/WAIT2.
- First access: word address[31:2], strobes = lanes a..3.
- Second access: word address[31:2]+1, wrapping modulo 2^30, strobes = remaining lower lanes.
- Store data rotated left by 8*a across the two words.
- Loads assembled from both words before extension.
- fault stays 0; latency grows by one full access.
- A misaligned access within one word (Half at a = 1) uses a single access.

Verification
REQ-026 SHALL: Lb, address 0x1003, rdata 0x80FFFFFF -> mem_wstrb 0, load_data 0xFFFFFF80; Lbu with the same inputs -> 0x00000080.
REQ-027 SHALL: Sh, address 0x2002, store_data 0x1234ABCD -> mem_addr 0x800, mem_wstrb 4'b1100, mem_wdata 0xABCDABCD, out_valid 2 cycles after accept with gnt immediate.
REQ-028 SHALL: Lw at 0x10 with mem_gnt delayed 3 cycles and rvalid 2 cycles after that -> mem_req held stable 4 cycles, single out_valid pulse, in_ready low throughout.
REQ-029 SHALL: Sw at 0x3 -> macro off: fault = 1, no mem_req; macro on: two accesses at word 0x0 (strb 4'b1000) then 0x1 (strb 4'b0111).
REQ-030 SHALL: reset asserted in WAIT followed by mem_rvalid -> no out_valid, FSM IDLE, load_data 0.

Source files
------------

// File: rtl/mips_memory_data_port.sv
// mips_memory_data_port: bridges the pipeline memory stage to a word-wide RAM
// with a valid/ready request side and a req/gnt + rvalid RAM side.
// Byte/half/word loads and stores are handled with little-endian lane
// steering. Loads are sign- or zero-extended.
// Optional feature: define MIPS_MEMORY_DATA_PORT_UNALIGNED_EN to split
// word-crossing misaligned accesses into two RAM accesses. When it is not
// defined, misaligned requests complete at once with fault set.
module mips_memory_data_port (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        write_enable_i,
    input  logic [1:0]  byte_enable_i,
    input  logic        byte_extend_i,
    input  logic [31:0] address_i,
    input  logic [31:0] store_data_i,
    output logic        out_valid_o,
    output logic [31:0] load_data_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned STRB_W  = 4;

    // Access size codes carried on byte_enable_i
    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    // FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
    localparam logic [2:0] ST_REQ2  = 3'd4;
    localparam logic [2:0] ST_WAIT2 = 3'd5;
`endif

    // Byte lanes touched by an access. Bits [7:4] fall into the next word.
    function automatic logic [7:0] lane_span(input logic [1:0] size, input logic [1:0] ofs);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'b0000_0001;
            SZ_HALF: base = 8'b0000_0011;
            SZ_WORD: base = 8'b0000_1111;
            default: base = 8'b0000_0000;
        endcase
        return base << ofs;
    endfunction

    // Half on an odd byte, or word not on a word boundary
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
        return ((size == SZ_HALF) && ofs[0]) || ((size == SZ_WORD) && (ofs != 2'd0));
    endfunction

    // Store operand replicated across all lanes for aligned accesses
    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {4{data[7:0]}};
            SZ_HALF: res = {2{data[15:0]}};
            default: res = data;
        endcase
        return res;
    endfunction

    // Pick the addressed bytes out of up to two words, then extend.
    // unsigned_ext = 1 zero-extends, 0 sign-extends.
    function automatic logic [31:0] extend_load(input logic [63:0] words,
                                                input logic [1:0]  size,
                                                input logic [1:0]  ofs,
                                                input logic        unsigned_ext);
        logic [31:0] sh;
        logic [31:0] res;
        sh = 32'(words >> {ofs, 3'b000});
        case (size)
            SZ_BYTE: res = unsigned_ext ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = unsigned_ext ? {16'h0000, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            SZ_WORD: res = sh;
            default: res = '0;
        endcase
        return res;
    endfunction

`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
    // Rotate the store operand left by 8*ofs so each byte lands on its lane
    function automatic logic [31:0] rotate_store(input logic [1:0] ofs, input logic [31:0] data);
        return 32'({data, data} >> (6'd32 - {1'b0, ofs, 3'b000}));
    endfunction
`endif

    logic [2:0]         state_q,     state_d;
    logic [1:0]         size_q,      size_d;
    logic               ext_q,       ext_d;
    logic [1:0]         ofs_q,       ofs_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               fault_q,     fault_d;
    logic [DATA_W-1:0]  load_data_q, load_data_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [WADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [STRB_W-1:0]  mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
    logic [STRB_W-1:0]  strb_hi_q,   strb_hi_d;
    logic [DATA_W-1:0]  rdata0_q,    rdata0_d;
    logic [7:0]         lanes;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        ext_d       = ext_q;
        ofs_d       = ofs_q;
        fault_d     = 1'b0;
        load_data_d = load_data_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = '0;
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
        strb_hi_d   = strb_hi_q;
        rdata0_d    = rdata0_q;
        lanes       = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    size_d = byte_enable_i;
                    ext_d  = byte_extend_i;
                    ofs_d  = address_i[1:0];
                    if (byte_enable_i == SZ_NONE) begin
                        state_d     = ST_DONE;
                        load_data_d = '0;
                    end
`ifndef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
                    else if (is_misaligned(byte_enable_i, address_i[1:0])) begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                    end
`endif
                    else begin
                        state_d    = ST_REQ;
                        mem_we_d   = write_enable_i;
                        mem_addr_d = address_i[31:2];
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
                        lanes       = lane_span(byte_enable_i, address_i[1:0]);
                        strb_hi_d   = lanes[7:4];
                        mem_wstrb_d = write_enable_i ? lanes[3:0] : 4'b0000;
                        mem_wdata_d = is_misaligned(byte_enable_i, address_i[1:0])
                                    ? rotate_store(address_i[1:0], store_data_i)
                                    : replicate(byte_enable_i, store_data_i);
`else
                        mem_wstrb_d = write_enable_i ? 4'(lane_span(byte_enable_i, address_i[1:0]))
                                                     : 4'b0000;
                        mem_wdata_d = replicate(byte_enable_i, store_data_i);
`endif
                    end
                end
            end

            ST_REQ: begin
                mem_wstrb_d = mem_wstrb_q;
                if (mem_gnt_i) begin
                    mem_wstrb_d = '0;
                    if (!mem_we_q) begin
                        state_d = ST_WAIT;
                    end
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
                    else if (strb_hi_q != 4'b0000) begin
                        state_d     = ST_REQ2;
                        mem_addr_d  = mem_addr_q + 30'd1;
                        mem_wstrb_d = strb_hi_q;
                    end
`endif
                    else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_WAIT: begin
                if (mem_rvalid_i) begin
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
                    if (strb_hi_q != 4'b0000) begin
                        rdata0_d   = mem_rdata_i;
                        state_d    = ST_REQ2;
                        mem_addr_d = mem_addr_q + 30'd1;
                    end else
`endif
                    begin
                        load_data_d = extend_load({32'h0, mem_rdata_i}, size_q, ofs_q, ext_q);
                        state_d     = ST_DONE;
                    end
                end
            end

`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
            ST_REQ2: begin
                mem_wstrb_d = mem_wstrb_q;
                if (mem_gnt_i) begin
                    mem_wstrb_d = '0;
                    state_d     = mem_we_q ? ST_DONE : ST_WAIT2;
                end
            end

            ST_WAIT2: begin
                if (mem_rvalid_i) begin
                    load_data_d = extend_load({mem_rdata_i, rdata0_q}, size_q, ofs_q, ext_q);
                    state_d     = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
        mem_req_d   = (state_d == ST_REQ) || (state_d == ST_REQ2);
`else
        mem_req_d   = (state_d == ST_REQ);
`endif
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_NONE;
            ext_q       <= 1'b0;
            ofs_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            load_data_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
            strb_hi_q   <= '0;
            rdata0_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            ext_q       <= ext_d;
            ofs_q       <= ofs_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
            strb_hi_q   <= strb_hi_d;
            rdata0_q    <= rdata0_d;
`endif
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign fault_o     = fault_q;
    assign load_data_o = load_data_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mips_memory_data_port.sv
// Self-checking bench for mips_memory_data_port: directed corner cases plus
// randomized accesses against a byte-addressed RAM reference model.
module tb_mips_memory_data_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [1:0]  be;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        out_valid;
    logic [31:0] load_data;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram [bit [31:0]];
    logic [31:0] ld_model;

    mips_memory_data_port dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .write_enable_i (we),
        .byte_enable_i  (be),
        .byte_extend_i  (ext),
        .address_i      (addr),
        .store_data_i   (sdata),
        .out_valid_o    (out_valid),
        .load_data_o    (load_data),
        .fault_o        (fault),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wstrb_o    (mem_wstrb),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Unwritten RAM bytes read back as a fixed address-derived pattern
    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        for (int l = 0; l < 4; l++) w[8*l +: 8] = rd_byte({a[31:2], 2'(l)});
        return w;
    endfunction

    // One complete request: drive it, play the RAM, check every observable step
    task automatic do_access(input logic a_we, input logic [1:0] a_sz, input logic a_ext,
                             input logic [31:0] a_addr, input logic [31:0] a_sd,
                             input int gdly, input int rdly);
        int          nb;
        logic        mis;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] v;
        nb  = (a_sz == 2'd3) ? 4 : (a_sz == 2'd2) ? 2 : (a_sz == 2'd1) ? 1 : 0;
        mis = ((a_sz == 2'd2) && a_addr[0]) || ((a_sz == 2'd3) && (a_addr[1:0] != 2'd0));
        exp_strb  = '0;
        exp_wdata = '0;
        for (int l = 0; l < 4; l++) begin
            if (nb > 0) exp_wdata[8*l +: 8] = a_sd[8*(l % nb) +: 8];
            if (a_we && (l >= int'(a_addr[1:0])) && (l < int'(a_addr[1:0]) + nb)) exp_strb[l] = 1'b1;
        end

        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; we = a_we; be = a_sz; ext = a_ext; addr = a_addr; sdata = a_sd;
        @(negedge clk);
        in_valid = 1'b0; addr = $urandom; sdata = $urandom; we = ~a_we; ext = ~a_ext;

        if (nb == 0 || mis) begin
            if (nb == 0) ld_model = '0;
            check("imm_out_valid", 32'(out_valid), 32'd1);
            check("imm_fault", 32'(fault), 32'(mis));
            check("imm_no_req", 32'(mem_req), 32'd0);
            check("imm_load_data", load_data, ld_model);
        end else begin
            for (int c = 0; c <= gdly; c++) begin
                check("req_valid", 32'(mem_req), 32'd1);
                check("req_we", 32'(mem_we), 32'(a_we));
                check("req_addr", 32'(mem_addr), 32'(a_addr[31:2]));
                check("req_wstrb", 32'(mem_wstrb), 32'(exp_strb));
                if (a_we) check("req_wdata", mem_wdata, exp_wdata);
                check("req_in_ready", 32'(in_ready), 32'd0);
                check("req_out_valid", 32'(out_valid), 32'd0);
                mem_gnt    = (c == gdly);
                mem_rvalid = (c < gdly) ? 1'($urandom) : 1'b0;
                mem_rdata  = $urandom;
                @(negedge clk);
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (a_we) begin
                for (int l = 0; l < 4; l++)
                    if (exp_strb[l]) ram[{a_addr[31:2], 2'(l)}] = exp_wdata[8*l +: 8];
            end else begin
                for (int c = 0; c <= rdly; c++) begin
                    check("wait_no_req", 32'(mem_req), 32'd0);
                    check("wait_out_valid", 32'(out_valid), 32'd0);
                    mem_rvalid = (c == rdly);
                    mem_rdata  = (c == rdly) ? rd_word(a_addr) : $urandom;
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = rd_byte(a_addr + 32'(i));
                if (!a_ext && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                ld_model = v;
            end
            check("done_out_valid", 32'(out_valid), 32'd1);
            check("done_fault", 32'(fault), 32'd0);
            check("done_load_data", load_data, ld_model);
            check("done_no_req", 32'(mem_req), 32'd0);
            check("done_wstrb", 32'(mem_wstrb), 32'd0);
        end
        @(negedge clk);
        check("after_out_valid", 32'(out_valid), 32'd0);
        check("after_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] ra;
        rst = 1'b1; in_valid = 1'b0; we = 1'b0; be = 2'd0; ext = 1'b0;
        addr = '0; sdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        ld_model = '0;

        // Reset wins over a simultaneous request and grant
        @(negedge clk);
        in_valid = 1'b1; we = 1'b1; be = 2'd3; addr = 32'h40; mem_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        in_valid = 1'b0; mem_gnt = 1'b0; rst = 1'b0;
        @(negedge clk);

        // Lb / Lbu at 0x1003 with word 0x80FFFFFF
        ram[32'h1000] = 8'hFF; ram[32'h1001] = 8'hFF; ram[32'h1002] = 8'hFF; ram[32'h1003] = 8'h80;
        do_access(1'b0, 2'd1, 1'b0, 32'h1003, 32'h0, 0, 0);
        check("lb_sign", load_data, 32'hFFFF_FF80);
        do_access(1'b0, 2'd1, 1'b1, 32'h1003, 32'h0, 0, 0);
        check("lbu_zero", load_data, 32'h0000_0080);

        // Sh at 0x2002, immediate grant
        do_access(1'b1, 2'd2, 1'b0, 32'h2002, 32'h1234_ABCD, 0, 0);
        do_access(1'b0, 2'd3, 1'b0, 32'h2000, 32'h0, 1, 1);
        check("sh_readback_hi", 32'(load_data[31:16]), 32'h0000_ABCD);

        // Lw at 0x10: grant after 3 cycles, rvalid 2 cycles later
        do_access(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 3, 2);

        // Sb at the top word exercises the full word address
        do_access(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_005A, 0, 0);

        // None request clears load_data without touching RAM
        do_access(1'b0, 2'd0, 1'b0, 32'h3000, 32'h0, 0, 0);

`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
        // Sw at 0x3 splits into word 0 (lane 3) then word 1 (lanes 0..2)
        in_valid = 1'b1; we = 1'b1; be = 2'd3; ext = 1'b0; addr = 32'h3; sdata = 32'hA1B2_C3D4;
        @(negedge clk);
        in_valid = 1'b0;
        check("split1_req", 32'(mem_req), 32'd1);
        check("split1_addr", 32'(mem_addr), 32'h0);
        check("split1_strb", 32'(mem_wstrb), 32'b1000);
        check("split1_data", mem_wdata, 32'hD4A1_B2C3);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("split2_req", 32'(mem_req), 32'd1);
        check("split2_addr", 32'(mem_addr), 32'h1);
        check("split2_strb", 32'(mem_wstrb), 32'b0111);
        check("split2_data", mem_wdata, 32'hD4A1_B2C3);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("split_out_valid", 32'(out_valid), 32'd1);
        check("split_fault", 32'(fault), 32'd0);
        @(negedge clk);
`else
        // Sw at 0x3 faults with no RAM access; load_data is untouched
        do_access(1'b0, 2'd1, 1'b1, 32'h1003, 32'h0, 0, 0);
        do_access(1'b1, 2'd3, 1'b0, 32'h3, 32'hA1B2_C3D4, 0, 0);
        check("sw_fault_keeps_ld", load_data, 32'h0000_0080);
        do_access(1'b0, 2'd2, 1'b0, 32'h1001, 32'h0, 0, 0);
`endif

        // Reset during REQ drops mem_req the next cycle
        in_valid = 1'b1; we = 1'b0; be = 2'd3; addr = 32'h20;
        @(negedge clk);
        in_valid = 1'b0;
        check("rreq_req", 32'(mem_req), 32'd1);
        rst = 1'b1; mem_gnt = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_gnt = 1'b0;
        check("rreq_req_dropped", 32'(mem_req), 32'd0);
        check("rreq_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("rreq_no_out_valid", 32'(out_valid), 32'd0);

        // Reset during WAIT, then the stale rvalid arrives
        in_valid = 1'b1; we = 1'b0; be = 2'd3; addr = 32'h20;
        @(negedge clk);
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rwait_in_wait", 32'(mem_req), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rwait_no_out_valid", 32'(out_valid), 32'd0);
        check("rwait_in_ready", 32'(in_ready), 32'd1);
        check("rwait_load_data", load_data, 32'd0);
        @(negedge clk);
        check("rwait_still_quiet", 32'(out_valid), 32'd0);
        ld_model = '0;

        // Randomized loads and stores in a small window so they alias
        for (int i = 0; i < 80; i++) begin
            sz = 2'($urandom_range(0, 3));
            ra = 32'h400 + 32'($urandom_range(0, 31));
`ifdef MIPS_MEMORY_DATA_PORT_UNALIGNED_EN
            if (sz == 2'd2) ra[0] = 1'b0;
            if (sz == 2'd3) ra[1:0] = 2'd0;
`endif
            do_access(1'($urandom), sz, 1'($urandom), ra, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
